// File: rtl/axi_uart_pkg.sv
// Shared constants, channel structs and FSM state encodings for the AXI UART model.
package axi_uart_pkg;

  localparam logic [15:0] UartThrOffset = 16'h0000;
  localparam logic [15:0] UartLsrOffset = 16'h0014;
  localparam logic [31:0] UartLsrValue  = 32'h0000_0060;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [1:0] RespOkay   = 2'b00;

  // Both enums share one package scope, so the idle labels carry a channel prefix.
  typedef enum logic [1:0] {WR_IDLE, WDATA, BRESP} wr_state_e;
  typedef enum logic       {RD_IDLE, RDATA}        rd_state_e;

  // Default request/response types: 64-bit data, 4-bit id, 32-bit address.
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } axi_uart_ax_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } axi_uart_w_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic       user;
  } axi_uart_b_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        user;
  } axi_uart_r_t;

  typedef struct packed {
    axi_uart_ax_t aw;
    logic         aw_valid;
    axi_uart_w_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_uart_ax_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_uart_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    axi_uart_b_t b;
    logic        r_valid;
    axi_uart_r_t r;
  } axi_uart_resp_t;

  // Register offset of an address: 4-byte stride inside the 64 KiB window.
  function automatic logic [15:0] reg_offset(input logic [15:0] addr);
    return {addr[15:2], 2'b00};
  endfunction

  // Next beat address; WRAP is deliberately handled like INCR.
  function automatic logic [15:0] next_addr(input logic [15:0] addr,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
    if (burst == BurstFixed) return addr;
    return addr + (16'd1 << size);
  endfunction

endpackage

// File: rtl/axi_uart_line_buf.sv
// Print line buffer for the UART model: collects THR bytes and prints one
// "[UART] <line>" per newline or full buffer. Only instantiated by
// axi_uart_core when UART_PRINT_EN is defined.
module axi_uart_line_buf #(
  parameter int unsigned LineLen = 128
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [7:0] data_i
);

  localparam int unsigned CntW = $clog2(LineLen + 1);

  logic [7:0]      buf_q [LineLen];
  logic [7:0]      buf_d [LineLen];
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] flush_len;
  logic            flush;

  function automatic string line_str(input logic [7:0] b [LineLen], input logic [CntW-1:0] len);
    string s;
    s = "";
    for (int i = 0; i < int'(len); i++) s = $sformatf("%s%c", s, b[i]);
    return s;
  endfunction

  // Append the byte, or flag a flush on newline / buffer full.
  always_comb begin
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    flush     = 1'b0;
    flush_len = cnt_q;
    if (valid_i) begin
      if (data_i == 8'h0A) begin
        flush = 1'b1;
        cnt_d = '0;
      end else begin
        buf_d[cnt_q] = data_i;
        if (cnt_q == CntW'(LineLen - 1)) begin
          flush     = 1'b1;
          flush_len = CntW'(LineLen);
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // Buffer state; a reset simply forgets whatever was collected.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
      if (flush) $display("[UART] %s", line_str(buf_d, flush_len));
    end
  end

endmodule

// File: rtl/axi_uart_core.sv
// AXI4 slave UART model: THR writes leave on tx_valid_o/tx_data_o, LSR reads
// always report an empty transmitter, every access completes OKAY.
// Optional console printing is enabled by defining UART_PRINT_EN.
module axi_uart_core
  import axi_uart_pkg::*;
#(
  parameter type         axi_req_t    = axi_uart_pkg::axi_uart_req_t,
  parameter type         axi_resp_t   = axi_uart_pkg::axi_uart_resp_t,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned LineLen      = 128
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       testmode_i,
  input  axi_req_t   axi_req_i,
  output axi_resp_t  axi_resp_o,
  output logic       tx_valid_o,
  output logic [7:0] tx_data_o
);

  localparam int unsigned OffW = $clog2(AxiDataWidth / 8);

  wr_state_e             wr_state_q, wr_state_d;
  logic [AxiIdWidth-1:0] wr_id_q, wr_id_d;
  logic [15:0]           wr_addr_q, wr_addr_d;
  logic [2:0]            wr_size_q, wr_size_d;
  logic [1:0]            wr_burst_q, wr_burst_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic [OffW-1:0]       wr_lane;

  rd_state_e             rd_state_q, rd_state_d;
  logic [AxiIdWidth-1:0] rd_id_q, rd_id_d;
  logic [15:0]           rd_addr_q, rd_addr_d;
  logic [2:0]            rd_size_q, rd_size_d;
  logic [1:0]            rd_burst_q, rd_burst_d;
  logic [7:0]            rd_len_q, rd_len_d;
  logic [OffW-1:0]       rd_lane;
  logic [31:0]           rd_word;
  logic [AxiDataWidth-1:0] rd_data;

  logic unused_inputs;
  assign unused_inputs = ^{testmode_i, axi_req_i};

  // Write FSM next state, address walk and THR byte strobe.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_id_d    = wr_id_q;
    wr_addr_d  = wr_addr_q;
    wr_size_d  = wr_size_q;
    wr_burst_d = wr_burst_q;
    tx_valid_d = 1'b0;
    tx_data_d  = tx_data_q;
    wr_lane    = wr_addr_q[OffW-1:0];
    unique case (wr_state_q)
      WR_IDLE: if (axi_req_i.aw_valid) begin
        wr_id_d    = AxiIdWidth'(axi_req_i.aw.id);
        wr_addr_d  = axi_req_i.aw.addr[15:0];
        wr_size_d  = axi_req_i.aw.size;
        wr_burst_d = axi_req_i.aw.burst;
        wr_state_d = WDATA;
      end
      WDATA: if (axi_req_i.w_valid) begin
        if (reg_offset(wr_addr_q) == UartThrOffset && axi_req_i.w.strb[wr_lane]) begin
          tx_valid_d = 1'b1;
          tx_data_d  = axi_req_i.w.data[8*int'(wr_lane) +: 8];
        end
        wr_addr_d = next_addr(wr_addr_q, wr_size_q, wr_burst_q);
        if (axi_req_i.w.last) wr_state_d = BRESP;
      end
      BRESP: if (axi_req_i.b_ready) wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Read FSM next state and beat counter.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_id_d    = rd_id_q;
    rd_addr_d  = rd_addr_q;
    rd_size_d  = rd_size_q;
    rd_burst_d = rd_burst_q;
    rd_len_d   = rd_len_q;
    unique case (rd_state_q)
      RD_IDLE: if (axi_req_i.ar_valid) begin
        rd_id_d    = AxiIdWidth'(axi_req_i.ar.id);
        rd_addr_d  = axi_req_i.ar.addr[15:0];
        rd_size_d  = axi_req_i.ar.size;
        rd_burst_d = axi_req_i.ar.burst;
        rd_len_d   = axi_req_i.ar.len;
        rd_state_d = RDATA;
      end
      RDATA: if (axi_req_i.r_ready) begin
        if (rd_len_q == 8'd0) begin
          rd_state_d = RD_IDLE;
        end else begin
          rd_len_d  = rd_len_q - 8'd1;
          rd_addr_d = next_addr(rd_addr_q, rd_size_q, rd_burst_q);
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Read data: register word placed on the 32-bit lane of the beat address.
  always_comb begin
    rd_lane = rd_addr_q[OffW-1:0];
    rd_word = (reg_offset(rd_addr_q) == UartLsrOffset) ? UartLsrValue : 32'h0;
    rd_data = AxiDataWidth'(rd_word) << (32 * int'(rd_lane >> 2));
  end

  // Channel handshakes follow the FSM states; everything is held quiet during reset.
  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = !rst_i && (wr_state_q == WR_IDLE);
    axi_resp_o.w_ready  = !rst_i && (wr_state_q == WDATA);
    axi_resp_o.b_valid  = !rst_i && (wr_state_q == BRESP);
    axi_resp_o.b.id     = wr_id_q;
    axi_resp_o.b.resp   = RespOkay;
    axi_resp_o.ar_ready = !rst_i && (rd_state_q == RD_IDLE);
    axi_resp_o.r_valid  = !rst_i && (rd_state_q == RDATA);
    axi_resp_o.r.id     = rd_id_q;
    axi_resp_o.r.data   = rd_data;
    axi_resp_o.r.resp   = RespOkay;
    axi_resp_o.r.last   = (rd_state_q == RDATA) && (rd_len_q == 8'd0);
  end

  // State registers for both FSMs and the tx strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state_q <= WR_IDLE;
      wr_id_q    <= '0;
      wr_addr_q  <= '0;
      wr_size_q  <= '0;
      wr_burst_q <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      rd_state_q <= RD_IDLE;
      rd_id_q    <= '0;
      rd_addr_q  <= '0;
      rd_size_q  <= '0;
      rd_burst_q <= '0;
      rd_len_q   <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_id_q    <= wr_id_d;
      wr_addr_q  <= wr_addr_d;
      wr_size_q  <= wr_size_d;
      wr_burst_q <= wr_burst_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      rd_state_q <= rd_state_d;
      rd_id_q    <= rd_id_d;
      rd_addr_q  <= rd_addr_d;
      rd_size_q  <= rd_size_d;
      rd_burst_q <= rd_burst_d;
      rd_len_q   <= rd_len_d;
    end
  end

  assign tx_valid_o = tx_valid_q;
  assign tx_data_o  = tx_data_q;

`ifdef UART_PRINT_EN
  axi_uart_line_buf #(.LineLen(LineLen)) i_line_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (tx_valid_q),
    .data_i  (tx_data_q)
  );
`else
  // No console output: tx_valid_o/tx_data_o are the only byte sink.
`endif

endmodule

// File: tb/tb_axi_uart_core.sv
// Directed bench for axi_uart_core: register decode, bursts, latency, reset abort.
module tb_axi_uart_core;
  import axi_uart_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           testmode;
  axi_uart_req_t  req;
  axi_uart_resp_t resp;
  logic           tx_valid;
  logic [7:0]     tx_data;

  int         vectors = 0;
  int         miscompares = 0;
  int         tx_cnt = 0;
  logic [7:0] tx_log [$];

  axi_uart_core #(
    .axi_req_t    (axi_uart_req_t),
    .axi_resp_t   (axi_uart_resp_t),
    .AxiDataWidth (64),
    .AxiIdWidth   (4),
    .LineLen      (128)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .testmode_i (testmode),
    .axi_req_i  (req),
    .axi_resp_o (resp),
    .tx_valid_o (tx_valid),
    .tx_data_o  (tx_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_valid) begin
      tx_cnt++;
      tx_log.push_back(tx_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return resp.aw_ready;
      1: return resp.w_ready;
      2: return resp.b_valid;
      3: return resp.ar_ready;
      4: return resp.r_valid;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input string tag, input int which, output int t);
    t = 0;
    while (!sig(which) && t < 20) begin
      tick;
      t++;
    end
    chk({tag, " seen"}, 64'(sig(which)), 64'd1);
  endtask

  task automatic axi_write(input string tag, input logic [31:0] addr, input logic [3:0] id,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                           input logic [63:0] data, input logic [7:0] strb);
    int t;
    req.aw.id = id; req.aw.addr = addr; req.aw.len = len;
    req.aw.size = size; req.aw.burst = burst; req.aw_valid = 1'b1;
    wait_sig({tag, " aw_ready"}, 0, t);
    tick;
    req.aw_valid = 1'b0;
    for (int beat = 0; beat <= int'(len); beat++) begin
      req.w.data = data; req.w.strb = strb;
      req.w.last = (beat == int'(len)); req.w_valid = 1'b1;
      wait_sig({tag, " w_ready"}, 1, t);
      if (beat == 0) chk({tag, " aw->w latency"}, 64'(t), 64'd0);
      tick;
    end
    req.w_valid = 1'b0; req.w.last = 1'b0;
    wait_sig({tag, " b_valid"}, 2, t);
    chk({tag, " w->b latency"}, 64'(t), 64'd0);
    chk({tag, " b.id"}, 64'(resp.b.id), 64'(id));
    chk({tag, " b.resp"}, 64'(resp.b.resp), 64'd0);
    req.b_ready = 1'b1;
    tick;
    req.b_ready = 1'b0;
    chk({tag, " aw_ready after B"}, 64'(resp.aw_ready), 64'd1);
  endtask

  task automatic axi_read(input string tag, input logic [31:0] addr, input logic [3:0] id,
                          input logic [7:0] len, input logic [63:0] exp0, input logic [63:0] exp1);
    int t;
    req.ar.id = id; req.ar.addr = addr; req.ar.len = len;
    req.ar.size = 3'd2; req.ar.burst = BurstIncr; req.ar_valid = 1'b1;
    wait_sig({tag, " ar_ready"}, 3, t);
    tick;
    req.ar_valid = 1'b0;
    for (int beat = 0; beat <= int'(len); beat++) begin
      wait_sig({tag, " r_valid"}, 4, t);
      if (beat == 0) chk({tag, " ar->r latency"}, 64'(t), 64'd0);
      chk({tag, " r.data"}, resp.r.data, (beat == 0) ? exp0 : exp1);
      chk({tag, " r.last"}, 64'(resp.r.last), 64'(beat == int'(len)));
      chk({tag, " r.id"}, 64'(resp.r.id), 64'(id));
      chk({tag, " r.resp"}, 64'(resp.r.resp), 64'd0);
      req.r_ready = 1'b1;
      tick;
      req.r_ready = 1'b0;
    end
    chk({tag, " ar_ready after R"}, 64'(resp.ar_ready), 64'd1);
  endtask

  initial begin
    int base;
    rst = 1'b1; testmode = 1'b0; req = '0;
    tick; tick;
    chk("reset aw_ready", 64'(resp.aw_ready), 64'd0);
    chk("reset ar_ready", 64'(resp.ar_ready), 64'd0);
    chk("reset w_ready", 64'(resp.w_ready), 64'd0);
    chk("reset b_valid", 64'(resp.b_valid), 64'd0);
    chk("reset r_valid", 64'(resp.r_valid), 64'd0);
    chk("reset tx_valid", 64'(tx_valid), 64'd0);
    chk("reset tx_data", 64'(tx_data), 64'd0);
    rst = 1'b0;
    #1;
    chk("post-reset aw_ready", 64'(resp.aw_ready), 64'd1);
    chk("post-reset ar_ready", 64'(resp.ar_ready), 64'd1);

    // Single THR byte, id 0x18d truncated to 4 bits = 0xD.
    base = tx_cnt;
    axi_write("thr A", 32'hC000_0000, 4'(12'h18D), 8'd0, 3'd2, BurstIncr, 64'h41, 8'h01);
    chk("thr A pulses", 64'(tx_cnt - base), 64'd1);
    chk("thr A byte", 64'(tx_log[$]), 64'h41);

    // LSR read on a 64-bit bus: offset 0x14 sits in the upper 32-bit lane.
    axi_read("lsr", 32'hC000_0014, 4'h3, 8'd0, 64'h0000_0060_0000_0000, 64'h0);
    // Two-beat INCR read 0x10 -> 0x14: zero word then LSR.
    axi_read("rd burst", 32'hC000_0010, 4'h9, 8'd1, 64'h0, 64'h0000_0060_0000_0000);

    // INCR burst of 4 from THR: only beat 0 (addr 0x00, lane 0 = 0x58) is a THR write.
    base = tx_cnt;
    axi_write("incr4", 32'hC000_0000, 4'h5, 8'd3, 3'd2, BurstIncr, 64'h5152_5354_5556_5758, 8'hFF);
    chk("incr4 pulses", 64'(tx_cnt - base), 64'd1);
    chk("incr4 byte", 64'(tx_log[$]), 64'h58);

    // FIXED burst of 3 on THR: every beat sends.
    base = tx_cnt;
    axi_write("fixed3", 32'hC000_0000, 4'h6, 8'd2, 3'd2, BurstFixed, 64'h5A, 8'h01);
    chk("fixed3 pulses", 64'(tx_cnt - base), 64'd3);

    // Byte lane 1 of THR via address 0x01.
    base = tx_cnt;
    axi_write("lane1", 32'hC000_0001, 4'h1, 8'd0, 3'd0, BurstIncr, 64'h4D00, 8'h02);
    chk("lane1 pulses", 64'(tx_cnt - base), 64'd1);
    chk("lane1 byte", 64'(tx_log[$]), 64'h4D);

    // Strobe for the selected lane clear, and a write to an unmapped offset.
    base = tx_cnt;
    axi_write("no strb", 32'hC000_0000, 4'h2, 8'd0, 3'd2, BurstIncr, 64'h77, 8'h02);
    axi_write("offset 8", 32'hC000_0008, 4'h2, 8'd0, 3'd2, BurstIncr, 64'h77, 8'hFF);
    chk("ignored writes pulses", 64'(tx_cnt - base), 64'd0);

    // "Hi\n"
    base = tx_cnt;
    axi_write("H", 32'hC000_0000, 4'h0, 8'd0, 3'd2, BurstIncr, 64'h48, 8'h01);
    axi_write("i", 32'hC000_0000, 4'h0, 8'd0, 3'd2, BurstIncr, 64'h69, 8'h01);
    axi_write("nl", 32'hC000_0000, 4'h0, 8'd0, 3'd2, BurstIncr, 64'h0A, 8'h01);
    chk("Hi pulses", 64'(tx_cnt - base), 64'd3);
    chk("Hi byte0", 64'(tx_log[tx_log.size()-3]), 64'h48);
    chk("Hi byte1", 64'(tx_log[tx_log.size()-2]), 64'h69);
    chk("Hi byte2", 64'(tx_log[tx_log.size()-1]), 64'h0A);

    // Simultaneous AW and AR.
    base = tx_cnt;
    req.aw.id = 4'hA; req.aw.addr = 32'hC000_0000; req.aw.len = 8'd0;
    req.aw.size = 3'd2; req.aw.burst = BurstIncr; req.aw_valid = 1'b1;
    req.ar.id = 4'hB; req.ar.addr = 32'hC000_0014; req.ar.len = 8'd0;
    req.ar.size = 3'd2; req.ar.burst = BurstIncr; req.ar_valid = 1'b1;
    chk("dual aw_ready", 64'(resp.aw_ready), 64'd1);
    chk("dual ar_ready", 64'(resp.ar_ready), 64'd1);
    tick;
    req.aw_valid = 1'b0; req.ar_valid = 1'b0;
    chk("dual w_ready", 64'(resp.w_ready), 64'd1);
    chk("dual r_valid", 64'(resp.r_valid), 64'd1);
    chk("dual r.data", resp.r.data, 64'h0000_0060_0000_0000);
    chk("dual r.id", 64'(resp.r.id), 64'hB);
    chk("dual r.last", 64'(resp.r.last), 64'd1);
    req.w.data = 64'h21; req.w.strb = 8'h01; req.w.last = 1'b1; req.w_valid = 1'b1;
    req.r_ready = 1'b1;
    tick;
    req.w_valid = 1'b0; req.w.last = 1'b0; req.r_ready = 1'b0;
    chk("dual b_valid", 64'(resp.b_valid), 64'd1);
    chk("dual b.id", 64'(resp.b.id), 64'hA);
    chk("dual b.resp", 64'(resp.b.resp), 64'd0);
    chk("dual r_valid done", 64'(resp.r_valid), 64'd0);
    chk("dual ar_ready back", 64'(resp.ar_ready), 64'd1);
    req.b_ready = 1'b1;
    tick;
    req.b_ready = 1'b0;
    chk("dual aw_ready back", 64'(resp.aw_ready), 64'd1);
    chk("dual pulses", 64'(tx_cnt - base), 64'd1);
    chk("dual byte", 64'(tx_log[$]), 64'h21);

    // Reset in the middle of a 4-beat write burst.
    req.aw.id = 4'h7; req.aw.addr = 32'hC000_0000; req.aw.len = 8'd3;
    req.aw.size = 3'd2; req.aw.burst = BurstIncr; req.aw_valid = 1'b1;
    tick;
    req.aw_valid = 1'b0;
    req.w.data = 64'h42; req.w.strb = 8'h01; req.w.last = 1'b0; req.w_valid = 1'b1;
    tick;
    chk("mid-burst w_ready", 64'(resp.w_ready), 64'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    req.w_valid = 1'b0;
    #1;
    chk("abort aw_ready", 64'(resp.aw_ready), 64'd1);
    chk("abort w_ready", 64'(resp.w_ready), 64'd0);
    chk("abort b_valid", 64'(resp.b_valid), 64'd0);
    chk("abort r_valid", 64'(resp.r_valid), 64'd0);
    chk("abort tx_valid", 64'(tx_valid), 64'd0);
    tick; tick; tick;
    chk("abort no B", 64'(resp.b_valid), 64'd0);

    base = tx_cnt;
    axi_write("after abort", 32'hC000_0000, 4'hC, 8'd0, 3'd2, BurstIncr, 64'h3F, 8'h01);
    chk("after abort pulses", 64'(tx_cnt - base), 64'd1);
    chk("after abort byte", 64'(tx_log[$]), 64'h3F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
